// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package imem_loader_pkg;

   localparam int unsigned PROGRAM_ADDRESS_WIDTH = 32;
   localparam int unsigned INSTRUCTION_WIDTH     = 32;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_t;

   // States in which the loader is consuming stream bytes.
   function automatic logic is_stream_state(input loader_state_t s);
      return (s == HDR) || (s == DATA) || (s == CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Little-endian byte-to-word packer: first accepted byte lands in bits 7:0.
// The completed word and its word_valid pulse are presented combinationally in
// the cycle the fourth byte is accepted, so the consumer can act with no bubble.
module byte_word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic [7:0]  byte_in,
   input  logic        accept,
   output logic [31:0] word,
   output logic        word_valid,
   output logic [1:0]  byte_idx
);

   logic [23:0] partial_q, partial_d;
   logic [1:0]  idx_q, idx_d;

   // Collect the lower three bytes and advance the byte index.
   always_comb begin
      partial_d = partial_q;
      idx_d     = idx_q;
      if (clear) begin
         partial_d = '0;
         idx_d     = '0;
      end else if (accept) begin
         case (idx_q)
            2'd0:    partial_d[7:0]   = byte_in;
            2'd1:    partial_d[15:8]  = byte_in;
            2'd2:    partial_d[23:16] = byte_in;
            default: ;
         endcase
         idx_d = idx_q + 2'd1;
      end
   end

   // Packer state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         partial_q <= '0;
         idx_q     <= '0;
      end else begin
         partial_q <= partial_d;
         idx_q     <= idx_d;
      end
   end

   // Fourth byte completes the word directly from the input.
   always_comb begin
      word       = {byte_in, partial_q};
      word_valid = accept && !clear && (idx_q == 2'd3);
      byte_idx   = idx_q;
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: header word count, packed instruction
// words, trailing 8-bit additive checksum. Holds the core until a verified image
// is resident.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH      = PROGRAM_ADDRESS_WIDTH,
   parameter int unsigned BASE_ADDR       = 0,
   parameter int unsigned MEM_DEPTH_WORDS = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [7:0]                   byte_data,
   input  logic                         byte_valid,
   output logic                         byte_ready,
   output logic                         mem_write_en,
   output logic [ADDR_WIDTH-1:0]        mem_address,
   output logic [INSTRUCTION_WIDTH-1:0] mem_write_data,
   output logic                         core_hold,
   output logic                         load_done,
   output logic                         load_error,
   output logic [ADDR_WIDTH-1:0]        words_loaded
);

   loader_state_t state_q, state_d;

   logic                         ready_q, ready_d;
   logic [31:0]                  count_q, count_d;
   logic [7:0]                   csum_q, csum_d;
   logic [ADDR_WIDTH-1:0]        words_q, words_d;
   logic                         we_q, we_d;
   logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
   logic [INSTRUCTION_WIDTH-1:0] wdata_q, wdata_d;

   logic        accept;
   logic        pack_accept;
   logic        pack_clear;
   logic [31:0] pack_word;
   logic        pack_valid;
   logic [1:0]  pack_idx;

   assign accept      = byte_valid && ready_q;
   assign pack_accept = accept && ((state_q == HDR) || (state_q == DATA));

   byte_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (pack_clear),
      .byte_in    (byte_data),
      .accept     (pack_accept),
      .word       (pack_word),
      .word_valid (pack_valid),
      .byte_idx   (pack_idx)
   );

   // Next-state, datapath updates and decoded status outputs.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      csum_d     = csum_q;
      words_d    = words_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      pack_clear = 1'b0;

      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d    = HDR;
               count_d    = '0;
               csum_d     = '0;
               words_d    = '0;
               pack_clear = 1'b1;
            end
         end
         HDR: begin
            if (pack_valid) begin
               count_d = pack_word;
               if (pack_word > MEM_DEPTH_WORDS) begin
                  state_d = ERR;
               end else if (pack_word == 32'd0) begin
                  state_d = CSUM;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               csum_d = csum_q + byte_data;
            end
            if (pack_valid) begin
               // Strobe goes out on the next cycle with the just-completed word.
               we_d    = 1'b1;
               addr_d  = ADDR_WIDTH'(BASE_ADDR) + {words_q[ADDR_WIDTH-3:0], 2'b00};
               wdata_d = pack_word;
               words_d = words_q + ADDR_WIDTH'(1);
               if ((32'(words_q) + 32'd1) == count_q) begin
                  state_d = CSUM;
               end
            end
         end
         CSUM: begin
            // Packer is word-aligned here; the checksum byte never enters it.
            if (accept && (pack_idx == 2'd0)) begin
               state_d = (byte_data == csum_q) ? DONE : ERR;
            end
         end
         default: state_d = IDLE;
      endcase

      ready_d    = is_stream_state(state_d);
      load_done  = (state_q == DONE);
      load_error = (state_q == ERR);
      core_hold  = (state_q != DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         count_q <= '0;
         csum_q  <= '0;
         words_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         count_q <= count_d;
         csum_q  <= csum_d;
         words_q <= words_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign byte_ready     = ready_q;
   assign mem_write_en   = we_q;
   assign mem_address    = addr_q;
   assign mem_write_data = wdata_q;
   assign words_loaded   = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every write strobe.
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic        mem_write_en;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        core_hold;
   logic        load_done;
   logic        load_error;
   logic [31:0] words_loaded;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  vectors = 0;
   int  errors  = 0;

   imem_loader dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .byte_data      (byte_data),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .mem_write_en   (mem_write_en),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .core_hold      (core_hold),
      .load_done      (load_done),
      .load_error     (load_error),
      .words_loaded   (words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Write monitor: every strobe must match the head of the scoreboard.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst && mem_write_en) begin
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                        mem_address, mem_write_data);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", mem_address, e.addr);
               check("write_data", mem_write_data, e.data);
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
      check({tag, "_mem_write_en"}, 32'(mem_write_en), 32'd0);
      check({tag, "_mem_address"}, mem_address, 32'd0);
      check({tag, "_mem_write_data"}, mem_write_data, 32'd0);
      check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
      check({tag, "_load_done"}, 32'(load_done), 32'd0);
      check({tag, "_load_error"}, 32'(load_error), 32'd0);
      check({tag, "_words_loaded"}, words_loaded, 32'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Present one byte until accepted; optional idle gap with junk data after it.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      byte_data  = b;
      byte_valid = 1'b1;
      while (!byte_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!byte_ready) begin
         vectors++;
         errors++;
         $display("FAIL handshake_timeout: byte_ready stayed 0, required 1");
      end
      @(posedge clk); #1;
      if (gap > 0) begin
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         repeat (gap) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic send_seq(input logic [7:0] s[$], input int gap);
      foreach (s[i]) send_byte(s[i], gap);
      byte_valid = 1'b0;
   endtask

   task automatic wait_end(input int lim);
      int n = 0;
      while (!(load_done || load_error) && n < lim) begin
         @(posedge clk); #1;
         n++;
      end
      if (!(load_done || load_error)) begin
         vectors++;
         errors++;
         $display("FAIL end_timeout: load_done/load_error stayed 0, required one set");
      end
   endtask

   initial begin
      // Reset asserted between clock edges takes effect immediately.
      #3 rst = 1'b0;
      #1 check_reset("rst");
      repeat (2) @(posedge clk);
      #1 check_reset("rst_hold");
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 check_reset("idle");

      // Single NOP, back-to-back bytes.
      exp_q.push_back('{addr: 32'h0, data: 32'h0000_0013});
      pulse_start();
      send_seq({8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13}, 0);
      wait_end(40);
      @(posedge clk); #1;
      check("nop_done", 32'(load_done), 32'd1);
      check("nop_error", 32'(load_error), 32'd0);
      check("nop_core_hold", 32'(core_hold), 32'd0);
      check("nop_words", words_loaded, 32'd1);
      check("nop_ready", 32'(byte_ready), 32'd0);

      // Two words with a gap after every byte.
      exp_q.push_back('{addr: 32'h0, data: 32'h0050_0093});
      exp_q.push_back('{addr: 32'h4, data: 32'h0010_8113});
      pulse_start();
      check("restart_core_hold", 32'(core_hold), 32'd1);
      check("restart_done_clr", 32'(load_done), 32'd0);
      send_seq({8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                8'h13, 8'h81, 8'h10, 8'h00, 8'h87}, 1);
      wait_end(40);
      check("two_done", 32'(load_done), 32'd1);
      check("two_words", words_loaded, 32'd2);
      check("two_addr_hold", mem_address, 32'h4);
      check("two_data_hold", mem_write_data, 32'h0010_8113);

      // Same image with a wrong checksum.
      exp_q.push_back('{addr: 32'h0, data: 32'h0050_0093});
      exp_q.push_back('{addr: 32'h4, data: 32'h0010_8113});
      pulse_start();
      send_seq({8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                8'h13, 8'h81, 8'h10, 8'h00, 8'h86}, 0);
      wait_end(40);
      check("bad_error", 32'(load_error), 32'd1);
      check("bad_done", 32'(load_done), 32'd0);
      check("bad_core_hold", 32'(core_hold), 32'd1);
      check("bad_words", words_loaded, 32'd2);

      // Word count 1025 exceeds depth: error straight after the header.
      pulse_start();
      check("ovf_error_clr", 32'(load_error), 32'd0);
      send_seq({8'h01, 8'h04, 8'h00, 8'h00}, 0);
      check("ovf_error", 32'(load_error), 32'd1);
      check("ovf_ready", 32'(byte_ready), 32'd0);
      byte_valid = 1'b1;
      byte_data  = 8'hAA;
      repeat (3) @(posedge clk);
      #1 byte_valid = 1'b0;
      check("ovf_words", words_loaded, 32'd0);

      // Word count 1024 is the largest legal value.
      pulse_start();
      send_seq({8'h00, 8'h04, 8'h00, 8'h00}, 0);
      check("max_error", 32'(load_error), 32'd0);
      check("max_ready", 32'(byte_ready), 32'd1);

      // Abort mid-image with reset, then load an empty image.
      #3 rst = 1'b0;
      #1 check_reset("max_abort");
      @(posedge clk); #1 rst = 1'b1;
      exp_q.push_back('{addr: 32'h0, data: 32'h0050_0093});
      pulse_start();
      send_seq({8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13}, 0);
      #3 rst = 1'b0;
      #1 check_reset("abort");
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 pulse_start();
      send_seq({8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0);
      wait_end(40);
      check("empty_done", 32'(load_done), 32'd1);
      check("empty_error", 32'(load_error), 32'd0);
      check("empty_core_hold", 32'(core_hold), 32'd0);
      check("empty_words", words_loaded, 32'd0);

      repeat (3) @(posedge clk);
      #1 check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for instruction memory. It accepts a byte stream over a valid/ready handshake: a 4-byte word-count header, the instruction words, then a checksum byte. It packs the bytes little-endian into 32-bit words and drives instruction memory's write port. It holds the core stalled until a complete, checksum-verified image is in memory; instruction fetch is the reader of the memory this block fills.

Parameters:
ADDR_WIDTH, PROGRAM_ADDRESS_WIDTH (32), width of memory byte address
BASE_ADDR, 0, byte address of first loaded word (word-aligned)
MEM_DEPTH_WORDS, 1024, maximum accepted word count

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; asynchronous, active-low (asserted when 0)
start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
byte_data  in  8  incoming stream byte
byte_valid  in  1  byte_data is valid
byte_ready  out  1  loader accepts a byte this cycle
mem_write_en  out  1  instruction memory write strobe
mem_address  out  ADDR_WIDTH  byte address of write
mem_write_data  out  INSTRUCTION_WIDTH  word to write
core_hold  out  1  stall/hold for the core pipeline
load_done  out  1  image loaded and checksum matched (level)
load_error  out  1  bad count or checksum mismatch (level)
words_loaded  out  ADDR_WIDTH  words written so far in current load

Behaviour:
- Reset values (async on rst=0): state IDLE; byte_ready=0; mem_write_en=0; mem_address=0; mem_write_data=0; core_hold=1; load_done=0; load_error=0; words_loaded=0; all counters and checksum = 0.
- Handshake: a byte transfers on a rising edge with byte_valid && byte_ready. byte_ready is registered and is 1 only in HDR, DATA and CSUM. byte_data may change freely when byte_valid=0.
- States:
  - IDLE: start moves to HDR; clears checksum, counters, load_done and load_error; core_hold=1.
  - HDR: 4 bytes, little-endian, give word count N.
    - N > MEM_DEPTH_WORDS: go to ERR.
    - N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: bytes are packed little-endian (first byte = bits 7:0).
    - On the 4th byte of a word, mem_write_en=1 for exactly one cycle on the following cycle.
    - That write uses mem_address = BASE_ADDR + 4*idx and the packed word.
    - words_loaded increments with the strobe.
    - After word N-1 is accepted, go to CSUM.
  - CSUM: 1 byte, compared to the 8-bit sum (mod 256) of all DATA bytes; header bytes are excluded.
    - Match: go to DONE.
    - Mismatch: go to ERR.
  - DONE: load_done=1, core_hold=0, byte_ready=0.
  - ERR: load_error=1, core_hold=1, byte_ready=0.
- start is ignored in HDR, DATA and CSUM. In DONE or ERR, start re-enters HDR with core_hold=1 and the flags cleared.
- mem_write_en is never asserted outside DATA. mem_address and mem_write_data hold their last values between strobes.
- Address arithmetic is ADDR_WIDTH-bit unsigned, and idx < N <= MEM_DEPTH_WORDS, so no wrap occurs.
- Back-to-back bytes (byte_valid held high) are accepted every cycle with no bubbles, including across word boundaries and state transitions.
- Reset mid-load aborts immediately. Memory contents already written are left as-is; a fresh start is required.
- Bytes beyond the checksum are not accepted (byte_ready=0).

Decomposition:
- Shared package common: PROGRAM_ADDRESS_WIDTH, INSTRUCTION_WIDTH, and a new typedef enum loader_state_t {IDLE, HDR, DATA, CSUM, DONE, ERR}.
- One natural sub-module, byte_word_packer. It takes a byte plus accept strobe and outputs a 32-bit word plus a word_valid pulse, with a 2-bit byte index and a clear input.

Test Plan:
- Reset then idle: rst=0 mid-cycle → all outputs at reset values immediately; core_hold=1, byte_ready=0 until start.
- Single NOP: start; bytes 01 00 00 00, 13 00 00 00, 13 → one write at addr 0x0 with data 0x00000013; load_done=1, core_hold=0, words_loaded=1.
- Two words with gapped valid: header 02 00 00 00; bytes 93 00 50 00 13 81 10 00; checksum 87 → writes 0x00500093@0x0 and 0x00108113@0x4; load_done=1.
- Bad checksum: same stream with checksum 86 → both words written, then load_error=1, core_hold=1, load_done=0.
- Count overflow: header with N=1025 (01 04 00 00) → ERR right after header, no mem_write_en, byte_ready=0.
- Abort and restart: rst=0 after 5 data bytes, then start with N=0 and checksum 00 → no writes after reset, load_done=1, words_loaded=0.
